// File: rtl/ioq_hdr_decoder.sv
// Strips module headers from the packet stream and turns the IOQ header into a
// queued {dst_ports, byte_len} descriptor; packets without usable ports are dropped.
module ioq_hdr_decoder #(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH/8,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int DESC_DEPTH_BITS   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic                         out_wr,
  input  logic                         out_rdy,
  output logic                         desc_valid,
  output logic [NUM_OUTPUT_QUEUES-1:0] desc_dst_ports,
  output logic [15:0]                  desc_byte_len,
  input  logic                         desc_rd,
  output logic [15:0]                  drop_cnt
);

  localparam int NQ    = NUM_OUTPUT_QUEUES;
  localparam int POS   = 48;
  localparam int DEPTH = 1 << DESC_DEPTH_BITS;
  localparam int DW    = NQ + 16;
  localparam int CW    = DESC_DEPTH_BITS + 1;
  localparam int PW    = DESC_DEPTH_BITS;

  localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(8'hFF);
  localparam logic [CW-1:0] NF_TH = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    HDRS,
    PAYLOAD,
    DROP
  } state_e;

  state_e state_q, state_d;

  logic            hdr_seen_q, hdr_seen_d;
  logic [NQ-1:0]   dst_q, dst_d;
  logic [15:0]     len_q, len_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic                  out_wr_q, out_wr_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic push;
  logic pop;
  logic fwd;
  logic ctrl_zero;
  logic is_ioq;

  always_comb begin
    state_d    = state_q;
    hdr_seen_d = hdr_seen_q;
    dst_d      = dst_q;
    len_d      = len_q;
    drop_cnt_d = drop_cnt_q;
    push       = 1'b0;
    fwd        = 1'b0;
    ctrl_zero  = (in_ctrl == '0);
    is_ioq     = (in_ctrl == IOQ_CTRL);

    if (in_wr) begin
      unique case (state_q)
        HDRS: begin
          if (!ctrl_zero) begin
            if (is_ioq) begin
              hdr_seen_d = 1'b1;
              dst_d      = in_data[POS +: NQ];
              len_d      = in_data[15:0];
            end
          end else if (hdr_seen_q && (dst_q != '0)) begin
            push    = 1'b1;
            fwd     = 1'b1;
            state_d = PAYLOAD;
          end else begin
            if (drop_cnt_q != 16'hFFFF) begin
              drop_cnt_d = drop_cnt_q + 16'd1;
            end
            state_d = DROP;
          end
        end
        PAYLOAD: begin
          fwd = 1'b1;
          if (!ctrl_zero) begin
            state_d    = HDRS;
            hdr_seen_d = 1'b0;
          end
        end
        DROP: begin
          if (!ctrl_zero) begin
            state_d    = HDRS;
            hdr_seen_d = 1'b0;
          end
        end
        default: state_d = HDRS;
      endcase
    end

    out_wr_d   = fwd;
    out_data_d = fwd ? in_data : '0;
    out_ctrl_d = fwd ? in_ctrl : '0;
  end

  // Descriptor FIFO: first-word fall-through, head read straight from mem_q
  always_comb begin
    pop   = desc_rd && (cnt_q != '0);
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wp_q] = {dst_q, len_q};
      wp_d        = wp_q + PW'(1);
    end
    if (pop) begin
      rp_d = rp_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= HDRS;
      hdr_seen_q <= 1'b0;
      dst_q      <= '0;
      len_q      <= '0;
      drop_cnt_q <= '0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      out_wr_q   <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      hdr_seen_q <= hdr_seen_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      drop_cnt_q <= drop_cnt_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      out_wr_q   <= out_wr_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Keep one slot spare so a packet already started can always push
  assign in_rdy         = out_rdy && (cnt_q < NF_TH);
  assign out_data       = out_data_q;
  assign out_ctrl       = out_ctrl_q;
  assign out_wr         = out_wr_q;
  assign drop_cnt       = drop_cnt_q;
  assign desc_valid     = (cnt_q != '0);
  assign desc_dst_ports = desc_valid ? mem_q[rp_q][DW-1:16] : '0;
  assign desc_byte_len  = desc_valid ? mem_q[rp_q][15:0] : '0;

endmodule

// File: doc/ioq_hdr_decoder.md
IOQ_HDR_DECODER -- requirements
Module: ioq_hdr_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, datapath width in bits.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, control width in bits.
REQ-003 SHALL have parameter NUM_OUTPUT_QUEUES, default 8, width of the destination-port bitmask.
REQ-004 SHALL have parameter DESC_DEPTH_BITS, default 2, log2 of descriptor FIFO depth.
REQ-005 SHALL have port clk, input, 1, sole clock; all state rising-edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low; state is reset while reset=0.
REQ-007 SHALL have ports in_data, in_ctrl, in_wr, in_rdy: inputs of DATA_WIDTH, CTRL_WIDTH and 1 bit, plus in_rdy output of 1 bit; upstream packet stream carrying module headers.
REQ-008 SHALL have ports out_data, out_ctrl, out_wr, out_rdy: outputs of DATA_WIDTH, CTRL_WIDTH and 1 bit, plus out_rdy input of 1 bit; stripped packet stream.
REQ-009 SHALL have port desc_valid, output, 1, descriptor FIFO not empty.
REQ-010 SHALL have port desc_dst_ports, output, NUM_OUTPUT_QUEUES, head descriptor destination bitmask.
REQ-011 SHALL have port desc_byte_len, output, 16, head descriptor byte length.
REQ-012 SHALL have port desc_rd, input, 1, pops the head descriptor when desc_valid=1.
REQ-013 SHALL have port drop_cnt, output, 16, count of dropped packets.

Function
REQ-014 SHALL define the IOQ header as a word with in_ctrl=IO_QUEUE_STAGE_NUM (0xFF): dst ports at [IOQ_DST_PORT_POS+NUM_OUTPUT_QUEUES-1:IOQ_DST_PORT_POS] (POS=48), byte length at [15:0].
REQ-015 SHALL accept an input word in any cycle with in_wr=1; upstream writes only while in_rdy=1.
REQ-016 SHALL drive in_rdy = out_rdy AND NOT desc_nearly_full, where nearly_full means occupancy >= depth-1.
REQ-017 SHALL run FSM states HDRS (reset state), PAYLOAD and DROP, advancing only on accepted words.
REQ-018 HDRS, word with ctrl!=0: SHALL not forward it; if ctrl=0xFF, latch dst ports and byte length and set hdr_seen.
REQ-019 HDRS, word with ctrl=0 and hdr_seen=1 and latched ports!=0: SHALL push {ports,byte_len}, forward the word and go to PAYLOAD.
REQ-020 HDRS, word with ctrl=0 and (hdr_seen=0 or latched ports=0): SHALL discard it, increment drop_cnt and go to DROP.
REQ-021 PAYLOAD: SHALL forward every word; a word with ctrl!=0 is EOP and SHALL return the FSM to HDRS, clearing hdr_seen.
REQ-022 DROP: SHALL discard words; a word with ctrl!=0 SHALL return the FSM to HDRS, clearing hdr_seen.
REQ-023 Multiple IOQ headers in one packet: last one wins.
REQ-024 Forwarded words SHALL appear on out_data/out_ctrl with out_wr=1 exactly one cycle after acceptance, unmodified; out_wr=0 otherwise.
REQ-025 Downstream SHALL provide at least 2 words of slack after deasserting out_rdy; the block issues at most 1 word after deassertion.
REQ-026 Descriptor FIFO: first-word fall-through, 2**DESC_DEPTH_BITS entries; desc_* fields valid while desc_valid=1.
REQ-027 Simultaneous push and pop SHALL leave occupancy unchanged; pop when empty is ignored; push never occurs when full (per REQ-016).
REQ-028 Descriptor push SHALL be visible on desc_valid the cycle after the pushing word is accepted.
REQ-029 drop_cnt SHALL saturate at 0xFFFF.

Reset
REQ-030 SHALL on reset=0 immediately set FSM=HDRS, hdr_seen=0, latched fields=0, out_wr=0, out_data=0, out_ctrl=0, descriptor FIFO empty (desc_valid=0, desc_* =0), drop_cnt=0.
REQ-031 Reset asserted mid-packet SHALL discard the partial packet; after release the next word is treated as a header word.

Verification
REQ-032 Packet: IOQ header with ports=0x04, byte_len=60, plus 1 other header, 8 payload words, EOP ctrl=0x10, out_rdy=1 -> 8 words out, 1-cycle latency, one descriptor {0x04,60}, drop_cnt=0.
REQ-033 Packet with IOQ ports=0x00 -> no output words, no descriptor, drop_cnt=1; the next valid packet passes normally.
REQ-034 Packet lacking IOQ header -> dropped, drop_cnt increments.
REQ-035 Four back-to-back valid packets with desc_rd=0 -> in_rdy drops once occupancy reaches 3; asserting desc_rd restores in_rdy; descriptors pop in order.
REQ-036 Toggle out_rdy low mid-payload -> in_rdy follows combinationally; no word lost, duplicated or reordered.
REQ-037 Pull reset low mid-PAYLOAD with 2 descriptors queued -> all outputs zero at once; the first post-reset packet decodes correctly.
